// File: rtl/irq_ctrl_16.sv
// irq_ctrl_16: sixteen-source interrupt controller.
// Rising edges on irq_in are captured into a pending register. Pending sources
// that are enabled in the mask compete through a round-robin arbiter, and the
// winner is presented to the core as irq/irq_vec until the core acknowledges.
//
// Handshake: irq acts as the valid signal and irq_ack as the ready signal.
// While irq=1, irq_vec is held stable. The request completes at the first
// rising clock edge where irq=1 and irq_ack=1 are both high. irq_ack has no
// effect while irq=0.
module irq_ctrl_16 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] irq_in,
   input  logic        mask_wr,
   input  logic [15:0] mask_din,
   input  logic        irq_ack,
   output logic        irq,
   output logic [3:0]  irq_vec,
   output logic [15:0] pending,
   output logic [15:0] mask
);

   typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [15:0] irq_q;
   logic [15:0] pending_q, pending_d;
   logic [15:0] mask_q, mask_d;
   logic [3:0]  ptr_q, ptr_d;
   logic        req_q, req_d;
   logic [3:0]  vec_q, vec_d;

   logic [15:0] edges;
   logic [15:0] eligible;
   logic        sel_found;
   logic [3:0]  sel_idx;
   logic [3:0]  cand;

   assign edges    = irq_in & ~irq_q;
   assign eligible = pending_q & mask_q;

   // Round-robin pick: first eligible source at or above ptr, wrapping 15 -> 0.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = 4'h0;
      cand      = 4'h0;
      for (int i = 0; i < 16; i++) begin
         cand = ptr_q + 4'(i);
         if (!sel_found && eligible[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Next-state logic: mask load, pending update, and request/ack sequencing.
   always_comb begin
      state_d   = state_q;
      mask_d    = mask_wr ? mask_din : mask_q;
      pending_d = pending_q;
      ptr_d     = ptr_q;
      req_d     = req_q;
      vec_d     = vec_q;
      case (state_q)
         IDLE: begin
            if (sel_found) begin
               vec_d   = sel_idx;
               req_d   = 1'b1;
               state_d = REQ;
            end
         end
         REQ: begin
            if (irq_ack) begin
               pending_d[vec_q] = 1'b0;
               ptr_d            = vec_q + 4'h1;
               req_d            = 1'b0;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh edge takes priority over the ack clear on the same source.
      pending_d = pending_d | edges;
   end

   // State registers. Reset clears every captured event immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         irq_q     <= 16'h0000;
         pending_q <= 16'h0000;
         mask_q    <= 16'h0000;
         ptr_q     <= 4'h0;
         req_q     <= 1'b0;
         vec_q     <= 4'h0;
      end else begin
         state_q   <= state_d;
         irq_q     <= irq_in;
         pending_q <= pending_d;
         mask_q    <= mask_d;
         ptr_q     <= ptr_d;
         req_q     <= req_d;
         vec_q     <= vec_d;
      end
   end

   assign irq     = req_q;
   assign irq_vec = vec_q;
   assign pending = pending_q;
   assign mask    = mask_q;

endmodule

// File: tb/tb_irq_ctrl_16.sv
// Directed testbench for irq_ctrl_16 with hand-computed expected values.
module tb_irq_ctrl_16;

   logic        clk;
   logic        rst_n;
   logic [15:0] irq_in;
   logic        mask_wr;
   logic [15:0] mask_din;
   logic        irq_ack;
   logic        irq;
   logic [3:0]  irq_vec;
   logic [15:0] pending;
   logic [15:0] mask;

   int checks = 0;
   int errors = 0;

   irq_ctrl_16 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .irq_in   (irq_in),
      .mask_wr  (mask_wr),
      .mask_din (mask_din),
      .irq_ack  (irq_ack),
      .irq      (irq),
      .irq_vec  (irq_vec),
      .pending  (pending),
      .mask     (mask)
   );

   // Clock: 10 ns period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Advance one clock edge; inputs and samples both happen 1 ns after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_mask(input logic [15:0] m);
      mask_wr  = 1'b1;
      mask_din = m;
      tick();
      mask_wr  = 1'b0;
   endtask

   task automatic ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   // Pulse lines for one edge, then one more edge so the grant is latched.
   task automatic pulse_and_grant(input logic [15:0] lines);
      irq_in = lines;
      tick();
      irq_in = 16'h0000;
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      irq_in   = 16'h0000;
      mask_wr  = 1'b0;
      mask_din = 16'h0000;
      irq_ack  = 1'b0;
      tick();
      tick();
      chk("rst_irq",     16'(irq),         16'h0000);
      chk("rst_vec",     16'(irq_vec),     16'h0000);
      chk("rst_pending", pending,          16'h0000);
      chk("rst_mask",    mask,             16'h0000);
      chk("rst_ptr",     16'(dut.ptr_q),   16'h0000);
      chk("rst_state",   16'(dut.state_q), 16'h0000);
      #2 rst_n = 1'b1;

      // Basic two-cycle latency on source 5.
      write_mask(16'hFFFF);
      chk("mask_load", mask, 16'hFFFF);
      irq_in = 16'h0020;
      tick();
      irq_in = 16'h0000;
      chk("t1_pending", pending,     16'h0020);
      chk("t1_irq_e0",  16'(irq),    16'h0000);
      tick();
      chk("t1_irq",     16'(irq),     16'h0001);
      chk("t1_vec",     16'(irq_vec), 16'h0005);
      ack();
      chk("t1_ack_irq", 16'(irq),       16'h0000);
      chk("t1_ack_pnd", pending,        16'h0000);
      chk("t1_ack_ptr", 16'(dut.ptr_q), 16'h0006);

      // Masked source stays pending; unmasking releases it.
      write_mask(16'h0000);
      irq_in = 16'h0008;
      tick();
      irq_in = 16'h0000;
      chk("t2_pending", pending, 16'h0008);
      tick();
      tick();
      chk("t2_masked_irq", 16'(irq), 16'h0000);
      write_mask(16'h0008);
      chk("t2_after_wr_irq", 16'(irq), 16'h0000);
      tick();
      chk("t2_irq", 16'(irq),     16'h0001);
      chk("t2_vec", 16'(irq_vec), 16'h0003);
      ack();
      chk("t2_ack_irq", 16'(irq), 16'h0000);

      // Level held high for 10 cycles gives a single event.
      write_mask(16'hFFFF);
      irq_in = 16'h0010;
      tick();
      chk("t4_hold_pnd", pending, 16'h0010);
      tick();
      chk("t4_hold_vec", 16'(irq_vec), 16'h0004);
      ack();
      for (int i = 0; i < 7; i++) tick();
      chk("t4_hold_pnd2", pending,  16'h0000);
      chk("t4_hold_irq2", 16'(irq), 16'h0000);
      irq_in = 16'h0000;
      tick();

      // Source 15 wraps the pointer to 0.
      pulse_and_grant(16'h8000);
      chk("t4_vec15", 16'(irq_vec), 16'h000F);
      ack();
      chk("t4_ptr_wrap", 16'(dut.ptr_q), 16'h0000);

      // Sources 2, 9, 14 together from ptr=0.
      irq_in = 16'h4204;
      tick();
      irq_in = 16'h0000;
      chk("t3_pending", pending, 16'h4204);
      tick();
      chk("t3_g1", 16'(irq_vec), 16'h0002);
      ack();
      chk("t3_g1_irq", 16'(irq),       16'h0000);
      chk("t3_g1_pnd", pending,        16'h4200);
      chk("t3_g1_ptr", 16'(dut.ptr_q), 16'h0003);
      tick();
      chk("t3_g2", 16'(irq_vec), 16'h0009);
      ack();
      tick();
      chk("t3_g3", 16'(irq_vec), 16'h000E);
      ack();
      chk("t3_ptr15", 16'(dut.ptr_q), 16'h000F);
      pulse_and_grant(16'h4004);
      chk("t3_wrap_g1", 16'(irq_vec), 16'h0002);
      ack();
      tick();
      chk("t3_wrap_g2", 16'(irq_vec), 16'h000E);
      ack();

      // New edge on the granted source in the ack cycle keeps it pending.
      pulse_and_grant(16'h0080);
      chk("t5_vec7", 16'(irq_vec), 16'h0007);
      irq_ack = 1'b1;
      irq_in  = 16'h0080;
      tick();
      irq_ack = 1'b0;
      irq_in  = 16'h0000;
      chk("t5_irq_low", 16'(irq), 16'h0000);
      chk("t5_pending", pending,  16'h0080);
      tick();
      chk("t5_regrant_irq", 16'(irq),     16'h0001);
      chk("t5_regrant_vec", 16'(irq_vec), 16'h0007);
      // Mask write during REQ does not withdraw the request.
      write_mask(16'h0000);
      chk("t5_mask_req_irq", 16'(irq),     16'h0001);
      chk("t5_mask_req_vec", 16'(irq_vec), 16'h0007);
      ack();
      chk("t5_done_irq", 16'(irq), 16'h0000);
      chk("t5_done_pnd", pending,  16'h0000);
      write_mask(16'hFFFF);

      // Ack held while idle changes nothing.
      irq_ack = 1'b1;
      tick();
      tick();
      tick();
      irq_ack = 1'b0;
      chk("t6_idle_irq",   16'(irq),         16'h0000);
      chk("t6_idle_state", 16'(dut.state_q), 16'h0000);
      chk("t6_idle_ptr",   16'(dut.ptr_q),   16'h0008);

      // Asynchronous reset mid-REQ.
      pulse_and_grant(16'h0002);
      chk("t6_req_vec", 16'(irq_vec), 16'h0001);
      irq_in = 16'h0010;
      tick();
      irq_in = 16'h0000;
      chk("t6_req_pnd", pending, 16'h0012);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_arst_irq", 16'(irq),     16'h0000);
      chk("t6_arst_vec", 16'(irq_vec), 16'h0000);
      chk("t6_arst_pnd", pending,      16'h0000);
      chk("t6_arst_msk", mask,         16'h0000);
      #2 rst_n = 1'b1;
      tick();
      chk("t6_post_irq", 16'(irq), 16'h0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
